// File: rtl/full_adder.sv
// One-bit full adder cell used at every position of the partial-product array.
// A half-adder position is this cell with cin tied low.
module full_adder (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = x ^ y ^ cin;
    assign cout = (x & y) | (cin & (x ^ y));

endmodule

// File: rtl/par_array_mult.sv
// Two-stage unsigned N x N array multiplier: operand registers feed a ripple-per-row
// AND/full-adder array, whose 2N-bit result is registered into z one edge later.
module par_array_mult #(
    parameter int N = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    output logic             out_valid,
    output logic [2*N-1:0]   z
);

    logic [N-1:0]   a_q, a_d;
    logic [N-1:0]   b_q, b_d;
    logic           v1_q, v2_q;
    logic [2*N-1:0] z_q, z_d;
    logic [2*N-1:0] prod;

    // Row i adds partial product (a_q & b_q[i]) to the upper N bits of row i-1.
    // Bit 0 of each row is final product bit i; row N-1 also yields the top N bits.
    for (genvar i = 0; i < N; i++) begin : g_row
        logic [N:0] acc;

        if (i == 0) begin : g_first
            assign acc = {1'b0, a_q & {N{b_q[0]}}};
        end else begin : g_add
            for (genvar j = 0; j < N; j++) begin : g_cell
                logic ci;
                logic co;
                logic s;

                if (j == 0) begin : g_half
                    assign ci = 1'b0;
                end else begin : g_full
                    assign ci = g_cell[j-1].co;
                end

                full_adder u_fa (
                    .x    (g_row[i-1].acc[j+1]),
                    .y    (a_q[j] & b_q[i]),
                    .cin  (ci),
                    .s    (s),
                    .cout (co)
                );

                assign acc[j] = s;
            end
            assign acc[N] = g_cell[N-1].co;
        end

        assign prod[i] = acc[0];
    end

    assign prod[2*N-1:N] = g_row[N-1].acc[N:1];

    // NOTE: every next-state value gets an explicit hold default so no latch is inferred.
    always_comb begin
        a_d = a_q;
        b_d = b_q;
        z_d = z_q;
        if (in_valid) begin
            a_d = a;
            b_d = b;
        end
        if (v1_q) begin
            z_d = prod;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q  <= '0;
            b_q  <= '0;
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            z_q  <= '0;
        end else begin
            a_q  <= a_d;
            b_q  <= b_d;
            v1_q <= in_valid;
            v2_q <= v1_q;
            z_q  <= z_d;
        end
    end

    assign out_valid = v2_q;
    assign z         = z_q;

endmodule

// File: tb/tb_par_array_mult.sv
// Scoreboard bench: drives an N=10 and an N=4 multiplier side by side, pushes a*b
// reference results on issue and pops/compares them whenever out_valid is seen.
module tb_par_array_mult;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;

    logic        iv10 = 1'b0;
    logic [9:0]  a10  = '0;
    logic [9:0]  b10  = '0;
    logic        ov10;
    logic [19:0] z10;

    logic        iv4 = 1'b0;
    logic [3:0]  a4  = '0;
    logic [3:0]  b4  = '0;
    logic        ov4;
    logic [7:0]  z4;

    int n_checks = 0;
    int n_pass   = 0;

    logic [19:0] q10[$];
    logic [7:0]  q4[$];
    logic [19:0] last10 = '0;
    logic [7:0]  last4  = '0;
    logic [19:0] e10;
    logic [7:0]  e4;
    int          run10     = 0;
    int          max_run10 = 0;

    always #5 clk = ~clk;

    par_array_mult #(.N(10)) dut10 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (iv10),
        .a         (a10),
        .b         (b10),
        .out_valid (ov10),
        .z         (z10)
    );

    par_array_mult #(.N(4)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (iv4),
        .a         (a4),
        .b         (b4),
        .out_valid (ov4),
        .z         (z4)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Drive one cycle of stimulus just after the rising edge and record the expected products.
    task automatic issue(input logic v10, input logic [9:0] x10, input logic [9:0] y10,
                         input logic v4,  input logic [3:0] x4,  input logic [3:0] y4);
        longint p10;
        longint p4;
        @(posedge clk);
        #1;
        iv10 = v10; a10 = x10; b10 = y10;
        iv4  = v4;  a4  = x4;  b4  = y4;
        p10 = longint'(x10) * longint'(y10);
        p4  = longint'(x4)  * longint'(y4);
        if (v10) q10.push_back(p10[19:0]);
        if (v4)  q4.push_back(p4[7:0]);
    endtask

    task automatic idle();
        issue(1'b0, 10'd0, 10'd0, 1'b0, 4'd0, 4'd0);
    endtask

    task automatic drain();
        int k = 0;
        while ((q10.size() != 0 || q4.size() != 0) && k < 20) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        check("drain_n10", q10.size(), 0);
        check("drain_n4", q4.size(), 0);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (ov10) begin
                run10++;
                if (run10 > max_run10) max_run10 = run10;
                if (q10.size() == 0) begin
                    check("n10_unexpected_valid", ov10, 0);
                end else begin
                    e10 = q10.pop_front();
                    check("n10_product", z10, e10);
                    last10 = e10;
                end
            end else begin
                run10 = 0;
                check("n10_hold", z10, last10);
            end

            if (ov4) begin
                if (q4.size() == 0) begin
                    check("n4_unexpected_valid", ov4, 0);
                end else begin
                    e4 = q4.pop_front();
                    check("n4_product", z4, e4);
                    last4 = e4;
                end
            end else begin
                check("n4_hold", z4, last4);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        #2 rst_n = 1'b0;
        #2;
        check("rst_z_n10", z10, 0);
        check("rst_valid_n10", ov10, 0);
        check("rst_z_n4", z4, 0);
        check("rst_valid_n4", ov4, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Two-cycle latency: nothing after the capture edge, valid after the next one.
        issue(1'b1, 10'd5, 10'd3, 1'b1, 4'd5, 4'd3);
        idle();
        @(negedge clk);
        check("latency_early_n10", ov10, 0);
        check("latency_early_n4", ov4, 0);
        @(negedge clk);
        check("latency_on_time_n10", ov10, 1);
        check("latency_on_time_n4", ov4, 1);

        // Five back-to-back pairs must come out as one unbroken run of five.
        max_run10 = 0;
        issue(1'b1, 10'd5,    10'd3,   1'b1, 4'd15, 4'd15);
        issue(1'b1, 10'd25,   10'd12,  1'b1, 4'd0,  4'd7);
        issue(1'b1, 10'd255,  10'd255, 1'b1, 4'd9,  4'd0);
        issue(1'b1, 10'd1023, 10'd1,   1'b1, 4'd1,  4'd15);
        issue(1'b1, 10'd0,    10'd511, 1'b1, 4'd15, 4'd1);
        idle();
        drain();
        check("back_to_back_run", max_run10, 5);

        issue(1'b1, 10'd1023, 10'd1023, 1'b1, 4'd15, 4'd15);
        idle();
        drain();
        check("max_operands_n10", z10, 20'd1046529);
        check("max_operands_n4", z4, 8'd225);

        // Reset one cycle after a valid input: outputs clear at once, no late pulse.
        issue(1'b1, 10'd7, 10'd9, 1'b1, 4'd7, 4'd9);
        idle();
        #3 rst_n = 1'b0;
        #1;
        check("midrst_z_n10", z10, 0);
        check("midrst_valid_n10", ov10, 0);
        check("midrst_z_n4", z4, 0);
        check("midrst_valid_n4", ov4, 0);
        q10.delete();
        q4.delete();
        last10 = '0;
        last4  = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("no_ghost_n10", ov10, 0);
            check("no_ghost_n4", ov4, 0);
        end

        for (int k = 0; k < 10000; k++) begin
            issue(($urandom % 4) != 0, 10'($urandom), 10'($urandom),
                  ($urandom % 4) != 0, 4'($urandom),  4'($urandom));
        end
        idle();
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/par_array_mult.md
PAR_ARRAY_MULT -- requirements
Module: par_array_mult

Interface
REQ-001 Parameter N, default 8: operand width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  qualifies a and b in the current cycle.
REQ-005 a  input  N  unsigned multiplicand.
REQ-006 b  input  N  unsigned multiplier.
REQ-007 out_valid  output  1  high when z holds a valid product.
REQ-008 z  output  2N  unsigned product a*b.
REQ-009 One clock domain; reset is asynchronous and active-low.

Function
REQ-010 The block SHALL compute z = a*b, unsigned, full 2N-bit width, with no truncation or overflow.
REQ-011 Input stage: on each rising edge with in_valid=1, a and b SHALL be captured into operand registers; with in_valid=0, the operand registers SHALL hold their values.
REQ-012 Array stage: the product SHALL be formed combinationally from the operand registers by an N x N AND partial-product array, reduced row by row with full/half-adder cells (ripple per row), with no behavioural '*' operator.
REQ-013 Output stage: the array result SHALL be registered into z on the following rising edge.
REQ-014 Latency SHALL be exactly 2 cycles: operands accepted at edge k appear on z, with out_valid=1, after edge k+1.
REQ-015 out_valid SHALL be the in_valid input delayed by 2 cycles; throughput SHALL be one product per cycle; there is no backpressure.
REQ-016 When out_valid=0, z SHALL hold its last value; it SHALL NOT be zeroed.
REQ-017 Boundaries: a=0 or b=0 SHALL give z=0; a=b=2^N-1 SHALL give z=(2^N-1)^2 with z[0]=1 and the top bit set.
REQ-018 Back-to-back valid inputs SHALL produce back-to-back valid outputs in order, with no bubbles.

Reset
REQ-019 Asserting rst_n=0 SHALL immediately clear the operand registers, z and both valid pipeline bits to 0, independent of clk.
REQ-020 Reset asserted mid-operation SHALL discard all in-flight products; no out_valid pulse SHALL occur for them after release.
REQ-021 After rst_n deasserts, the first in_valid accepted SHALL follow the normal 2-cycle latency.

Structure
REQ-022 No shared package SHALL be required; N is the only constant, passed as a parameter.
REQ-023 One sub-module, full_adder (inputs x, y, cin; outputs s, cout), SHALL be instantiated per array cell through generate loops; a half-adder position SHALL use a full_adder with cin=0.
REQ-024 Pipeline registers SHALL reside in par_array_mult only.

Verification (N=10)
REQ-025 a=5, b=3, in_valid=1 -> z=15, out_valid=1 two cycles later.
REQ-026 a=25, b=12 -> z=300; a=255, b=255 -> z=65025.
REQ-027 a=1023, b=1 -> z=1023; a=0, b=511 -> z=0; a=1023, b=1023 -> z=1046529.
REQ-028 Five consecutive valid pairs from REQ-025..027 -> five consecutive out_valid cycles with results in order.
REQ-029 rst_n pulsed low one cycle after a valid input -> z=0, out_valid=0 at once and no out_valid pulse for that input afterwards.
REQ-030 Random sweep of 10,000 operand pairs at N=10 and at N=4 -> z equals the a*b reference model for every pair.
